// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the load/store unit: access-size
//               encodings, LSU state encoding and the default data width.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // req_size encodings
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE    = 2'd0,
        LSU_BUS_REQ = 2'd1,
        LSU_WAIT    = 2'd2,
        LSU_RESP    = 2'd3
    } lsu_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational byte-lane logic for the load/store unit.
//               Store side: alignment check, byte enables, lane-replicated
//               write data. Load side: lane extract and sign/zero extension.
// Ports       : i_st_*  request-side size/offset/data/direction
//               o_misaligned, o_be, o_wdata_rep  request-side results
//               i_ld_*, i_rdata  latched access info plus bus read data
//               o_ld_data  extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import riscv_pkg::*;
#(
    parameter  int XLEN = XLEN_DEFAULT,
    localparam int NB   = XLEN / 8,
    localparam int OFS  = $clog2(NB)
) (
    input  logic [1:0]      i_st_size,
    input  logic            i_st_we,
    input  logic [OFS-1:0]  i_st_ofs,
    input  logic [XLEN-1:0] i_st_wdata,
    output logic            o_misaligned,
    output logic [NB-1:0]   o_be,
    output logic [XLEN-1:0] o_wdata_rep,
    input  logic [1:0]      i_ld_size,
    input  logic            i_ld_unsigned,
    input  logic [OFS-1:0]  i_ld_ofs,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_ld_data
);

    localparam logic [NB-1:0] c_mask_b = NB'(1);
    localparam logic [NB-1:0] c_mask_h = NB'(3);
    localparam logic [NB-1:0] c_mask_w = NB'(15);

    logic [NB-1:0]   w_mask;
    logic [OFS-1:0]  w_amask;
    logic [XLEN-1:0] w_shift;

    always_comb begin
        w_mask      = '1;
        w_amask     = OFS'(7);
        o_wdata_rep = i_st_wdata;
        case (i_st_size)
            SZ_B: begin
                w_mask      = c_mask_b;
                w_amask     = '0;
                o_wdata_rep = {NB{i_st_wdata[7:0]}};
            end
            SZ_H: begin
                w_mask      = c_mask_h;
                w_amask     = OFS'(1);
                o_wdata_rep = {(NB/2){i_st_wdata[15:0]}};
            end
            SZ_W: begin
                w_mask      = c_mask_w;
                w_amask     = OFS'(3);
                o_wdata_rep = {(NB/4){i_st_wdata[31:0]}};
            end
            default: begin
                w_mask      = '1;
                w_amask     = OFS'(7);
                o_wdata_rep = i_st_wdata;
            end
        endcase
        // A dword access has no legal encoding on a 32-bit datapath.
        o_misaligned = (|(i_st_ofs & w_amask)) || ((XLEN == 32) && (i_st_size == SZ_D));
        // Loads read the whole lane word; only stores need a narrow mask.
        o_be = i_st_we ? (w_mask << i_st_ofs) : '1;
    end

    always_comb begin
        w_shift   = i_rdata >> {i_ld_ofs, 3'b000};
        o_ld_data = w_shift;
        case (i_ld_size)
            SZ_B: begin
                if (i_ld_unsigned) o_ld_data = XLEN'(w_shift[7:0]);
                else               o_ld_data = XLEN'($signed(w_shift[7:0]));
            end
            SZ_H: begin
                if (i_ld_unsigned) o_ld_data = XLEN'(w_shift[15:0]);
                else               o_ld_data = XLEN'($signed(w_shift[15:0]));
            end
            SZ_W: begin
                if (i_ld_unsigned) o_ld_data = XLEN'(w_shift[31:0]);
                else               o_ld_data = XLEN'($signed(w_shift[31:0]));
            end
            default: o_ld_data = w_shift;
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Load/store unit between decode/execute and the data bus.
//               Valid/ready core request, one access in flight, bus FSM
//               IDLE -> BUS_REQ -> WAIT -> RESP, one-cycle response pulse.
//               Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
// Ports       : req_*  core request channel (req_ready high only in IDLE)
//               rsp_*  one-cycle completion with data/rd/error
//               mem_*  data-memory bus request/response
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import riscv_pkg::*;
#(
    parameter  int XLEN           = XLEN_DEFAULT,
    parameter  int ADDR_W         = 32,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int NB             = XLEN / 8,
    localparam int OFS            = $clog2(NB)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic              rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [NB-1:0]     mem_be,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rsp_err
);

    localparam logic [1:0] ST_IDLE    = LSU_IDLE;
    localparam logic [1:0] ST_BUS_REQ = LSU_BUS_REQ;
    localparam logic [1:0] ST_WAIT    = LSU_WAIT;
    localparam logic [1:0] ST_RESP    = LSU_RESP;

    logic [1:0]        r_state;
    logic              r_we;
    logic [1:0]        r_size;
    logic              r_uns;
    logic [OFS-1:0]    r_ofs;
    logic [4:0]        r_rd;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [NB-1:0]     r_mem_be;
    logic [XLEN-1:0]   r_mem_wdata;
    logic [XLEN-1:0]   r_rsp_rdata;
    logic [4:0]        r_rsp_rd;
    logic              r_rsp_err;

    logic              w_misaligned;
    logic [NB-1:0]     w_be;
    logic [XLEN-1:0]   w_wdata_rep;
    logic [XLEN-1:0]   w_ld_data;
    logic              w_timeout;

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_st_size     (req_size),
        .i_st_we       (req_we),
        .i_st_ofs      (req_addr[OFS-1:0]),
        .i_st_wdata    (req_wdata),
        .o_misaligned  (w_misaligned),
        .o_be          (w_be),
        .o_wdata_rep   (w_wdata_rep),
        .i_ld_size     (r_size),
        .i_ld_unsigned (r_uns),
        .i_ld_ofs      (r_ofs),
        .i_rdata       (mem_rdata),
        .o_ld_data     (w_ld_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    // Cleared on the accept that enters BUS_REQ, so the first bus cycle counts as 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_cnt <= '0;
        end else if ((r_state == ST_BUS_REQ) || (r_state == ST_WAIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // TIMEOUT_CYCLES is always >= 1, so the watchdog never fires here.
    assign w_timeout = (TIMEOUT_CYCLES < 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_size      <= SZ_B;
            r_uns       <= 1'b0;
            r_ofs       <= '0;
            r_rd        <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_rsp_rdata <= '0;
            r_rsp_rd    <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we   <= req_we;
                        r_size <= req_size;
                        r_uns  <= req_unsigned;
                        r_ofs  <= req_addr[OFS-1:0];
                        r_rd   <= req_rd;
                        if (w_misaligned) begin
                            r_state     <= ST_RESP;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_rsp_rd    <= req_we ? 5'd0 : req_rd;
                        end else begin
                            r_state     <= ST_BUS_REQ;
                            r_mem_addr  <= {req_addr[ADDR_W-1:OFS], {OFS{1'b0}}};
                            r_mem_we    <= req_we;
                            r_mem_be    <= w_be;
                            r_mem_wdata <= w_wdata_rep;
                        end
                    end
                end
                ST_BUS_REQ: begin
                    // A completed handshake wins over a watchdog expiry in the same cycle.
                    if (mem_req_ready) begin
                        r_state <= ST_WAIT;
                    end else if (w_timeout) begin
                        r_state     <= ST_RESP;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_rd    <= r_we ? 5'd0 : r_rd;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        r_state     <= ST_RESP;
                        r_rsp_err   <= mem_rsp_err;
                        r_rsp_rdata <= (mem_rsp_err || r_we) ? '0 : w_ld_data;
                        r_rsp_rd    <= r_we ? 5'd0 : r_rd;
                    end else if (w_timeout) begin
                        r_state     <= ST_RESP;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_rd    <= r_we ? 5'd0 : r_rd;
                    end
                end
                default: begin
                    // RESP: clear the response so it is only visible during the pulse.
                    r_state     <= ST_IDLE;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                    r_rsp_rd    <= '0;
                end
            endcase
        end
    end

    assign req_ready     = (r_state == ST_IDLE);
    assign mem_req_valid = (r_state == ST_BUS_REQ);
    assign mem_addr      = r_mem_addr;
    assign mem_we        = r_mem_we;
    assign mem_be        = r_mem_be;
    assign mem_wdata     = r_mem_wdata;
    assign rsp_valid     = (r_state == ST_RESP);
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_rd        = r_rsp_rd;
    assign rsp_err       = r_rsp_err;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit (XLEN=32). Expected
//               responses are queued when a request is driven and compared
//               when rsp_valid pulses, including response latency.
//               Watchdog scenario is exercised when LSU_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_rsp_err = 1'b0;

    load_store_unit #(
        .XLEN           (32),
        .ADDR_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rd        (req_rd),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_rd        (rsp_rd),
        .rsp_err       (rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_be        (mem_be),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .mem_rsp_err   (mem_rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        int          t0;
        int          lat;
    } exp_t;

    exp_t sb[$];

    // Response monitor: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_rd", rsp_rd, e.rd);
                check("rsp_err", rsp_err, e.err);
                check("rsp_latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    // One access: drive request, act as the bus, queue the expected response.
    task automatic lsu_access(
        input logic        we,
        input logic [1:0]  size,
        input logic        uns,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [4:0]  rd,
        input logic [31:0] bus_rdata,
        input int          delay,
        input logic        bus_err,
        input logic        to_bus,
        input logic        stray,
        input logic [31:0] exp_rdata,
        input logic        exp_err,
        input logic [3:0]  exp_be,
        input logic [31:0] exp_wdata
    );
        exp_t e;
        logic [31:0] exp_addr;
        exp_addr = {addr[31:2], 2'b00};
        check("req_ready_idle", req_ready, 1'b1);
        req_valid     = 1'b1;
        req_we        = we;
        req_size      = size;
        req_unsigned  = uns;
        req_addr      = addr;
        req_wdata     = wdata;
        req_rd        = rd;
        // A bus response arriving in the accept cycle must be ignored.
        mem_rsp_valid = stray;
        mem_rsp_err   = stray;
        mem_rdata     = 32'h5A5A_5A5A;
        e.rdata = exp_rdata;
        e.rd    = we ? 5'd0 : rd;
        e.err   = exp_err;
        e.t0    = cyc;
        e.lat   = to_bus ? (3 + delay) : 1;
        sb.push_back(e);
        @(negedge clk);
        req_valid     = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_err   = 1'b0;
        if (to_bus) begin
            for (int i = 0; i <= delay; i++) begin
                check("mem_req_valid", mem_req_valid, 1'b1);
                check("mem_addr", mem_addr, exp_addr);
                check("mem_be", mem_be, exp_be);
                check("mem_we", mem_we, we);
                if (we) check("mem_wdata", mem_wdata, exp_wdata);
                mem_req_ready = (i == delay);
                if (i < delay) @(negedge clk);
            end
            @(negedge clk);
            mem_req_ready = 1'b0;
            check("mem_req_valid_wait", mem_req_valid, 1'b0);
            mem_rsp_valid = 1'b1;
            mem_rsp_err   = bus_err;
            mem_rdata     = bus_rdata;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            mem_rsp_err   = 1'b0;
        end else begin
            check("mem_req_valid_misaligned", mem_req_valid, 1'b0);
        end
        drain();
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset_mem_req_valid", mem_req_valid, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_mem_be", mem_be, 4'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_mem_wdata", mem_wdata, 32'h0);
        check("reset_mem_we", mem_we, 1'b0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err", rsp_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_req_ready", req_ready, 1'b1);

        //          we    sz     uns   addr          wdata         rd     bus_rdata     dly err   bus   stray exp_rdata     e_err be     exp_wdata
        lsu_access(1'b0, 2'b10, 1'b0, 32'h100,      32'h0,        5'd5,  32'hDEADBEEF, 0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 4'hF, 32'h0);
        lsu_access(1'b0, 2'b00, 1'b0, 32'h103,      32'h0,        5'd6,  32'h80123456, 0, 1'b0, 1'b1, 1'b0, 32'hFFFFFF80, 1'b0, 4'hF, 32'h0);
        lsu_access(1'b0, 2'b00, 1'b1, 32'h103,      32'h0,        5'd7,  32'h80123456, 0, 1'b0, 1'b1, 1'b0, 32'h00000080, 1'b0, 4'hF, 32'h0);
        lsu_access(1'b1, 2'b01, 1'b0, 32'h102,      32'h1234ABCD, 5'd8,  32'h55555555, 0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 4'hC, 32'hABCDABCD);
        lsu_access(1'b0, 2'b10, 1'b0, 32'h101,      32'h0,        5'd9,  32'h0,        0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 4'hF, 32'h0);
        lsu_access(1'b0, 2'b11, 1'b0, 32'h100,      32'h0,        5'd10, 32'h0,        0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 4'hF, 32'h0);
        lsu_access(1'b0, 2'b10, 1'b0, 32'h104,      32'h0,        5'd11, 32'h12345678, 5, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 4'hF, 32'h0);
        lsu_access(1'b0, 2'b01, 1'b0, 32'h102,      32'h0,        5'd12, 32'h80011234, 0, 1'b0, 1'b1, 1'b0, 32'hFFFF8001, 1'b0, 4'hF, 32'h0);
        lsu_access(1'b0, 2'b01, 1'b1, 32'h100,      32'h0,        5'd13, 32'h1234F00D, 1, 1'b0, 1'b1, 1'b0, 32'h0000F00D, 1'b0, 4'hF, 32'h0);
        lsu_access(1'b1, 2'b00, 1'b0, 32'h101,      32'h000000AB, 5'd14, 32'h0,        0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 4'h2, 32'hABABABAB);
        lsu_access(1'b1, 2'b10, 1'b0, 32'h108,      32'hCAFEF00D, 5'd15, 32'h0,        2, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 4'hF, 32'hCAFEF00D);
        lsu_access(1'b0, 2'b10, 1'b0, 32'h10C,      32'h0,        5'd16, 32'h11223344, 0, 1'b0, 1'b1, 1'b1, 32'h11223344, 1'b0, 4'hF, 32'h0);
        lsu_access(1'b1, 2'b01, 1'b0, 32'h103,      32'h0000BEEF, 5'd17, 32'h0,        0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 4'h8, 32'h0);

        // Reset during BUS_REQ: mem_req_valid must drop without a clock edge.
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h200; req_rd = 5'd3;
        @(negedge clk);
        req_valid = 1'b0;
        check("bus_req_before_reset", mem_req_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1 check("async_reset_mem_req_valid", mem_req_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("req_ready_after_reset1", req_ready, 1'b1);

        // Reset during WAIT: the access is lost, no response, later bus reply ignored.
        req_valid = 1'b1; req_addr = 32'h204; req_rd = 5'd4;
        @(negedge clk);
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("wait_before_reset", mem_req_valid, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rdata = 32'hBADBAD00;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        check("req_ready_after_reset2", req_ready, 1'b1);
        repeat (4) @(negedge clk);
        check("no_rsp_after_reset", rsp_valid, 1'b0);

`ifdef LSU_TIMEOUT_EN
        // Watchdog: bus accepts but never responds; error pulse after 8 bus cycles.
        begin
            exp_t e;
            req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h300; req_rd = 5'd21;
            e.rdata = 32'h0; e.rd = 5'd21; e.err = 1'b1; e.t0 = cyc; e.lat = 9;
            sb.push_back(e);
            @(negedge clk);
            req_valid = 1'b0;
            mem_req_ready = 1'b1;
            @(negedge clk);
            mem_req_ready = 1'b0;
            drain();
            mem_rsp_valid = 1'b1;
            mem_rdata = 32'h0BADF00D;
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            repeat (3) @(negedge clk);
            check("late_rsp_ignored", rsp_valid, 1'b0);
            check("timeout_req_ready", req_ready, 1'b1);
        end
`endif

        // Final access after all abnormal scenarios confirms normal operation.
        lsu_access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 5'd30, 32'hA5A5C3C3, 0, 1'b0, 1'b1, 1'b0, 32'hA5A5C3C3, 1'b0, 4'hF, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: got stalled expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule : tb_load_store_unit
`default_nettype wire
